// File: rtl/time_entry_loader.sv
`default_nettype none
// ============================================================================
//  Module      : time_entry_loader
//  Description : Microwave timer front end. Shifts keypad digits into a
//                three-digit BCD entry (min / tens / ones), loads it into the
//                down-counter chain, then gates counting and heating while
//                watching the chain's all-zero flag and the door switch.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_entry_loader #(
    parameter int unsigned MAX_TENS  = 5,
    parameter int unsigned MAX_DIGIT = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       tick,
    input  logic       timer_zero,
    output logic [3:0] data_min,
    output logic [3:0] data_tens,
    output logic [3:0] data_ones,
    output logic       loadn,
    output logic       en_count,
    output logic       heat_on,
    output logic       done,
    output logic       entry_err
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ENTRY = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_RUN   = 3'd3;
    localparam logic [2:0] c_ST_PAUSE = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [3:0] c_MAX_TENS  = 4'(MAX_TENS);
    localparam logic [3:0] c_MAX_DIGIT = 4'(MAX_DIGIT);

    logic [2:0] r_state;
    logic [3:0] r_min;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_loadn;
    logic       r_en_count;
    logic       r_heat_on;
    logic       r_done;
    logic       r_entry_err;

    logic w_key_ok;
    logic w_all_zero;
    logic w_tens_bad;

    // Entry qualification: legal key code, empty entry, out-of-range tens digit
    always_comb begin
        w_key_ok   = key_valid && (key_code <= c_MAX_DIGIT);
        w_all_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
        w_tens_bad = (r_tens > c_MAX_TENS);
    end

    // Controller FSM; every output is registered alongside the state
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= c_ST_IDLE;
            r_min       <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_loadn     <= 1'b1;
            r_en_count  <= 1'b0;
            r_heat_on   <= 1'b0;
            r_done      <= 1'b0;
            r_entry_err <= 1'b0;
        end else begin
            // Strobe-type outputs default to inactive every cycle
            r_loadn     <= 1'b1;
            r_en_count  <= 1'b0;
            r_done      <= 1'b0;
            r_entry_err <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_ENTRY: begin
                    if (stop) begin
                        r_min   <= 4'd0;
                        r_tens  <= 4'd0;
                        r_ones  <= 4'd0;
                        r_state <= c_ST_IDLE;
                    end else if ((r_state == c_ST_ENTRY) && start) begin
                        // A key arriving with start is dropped on purpose
                        if (w_all_zero) begin
                            r_state <= c_ST_ENTRY;
                        end else if (w_tens_bad) begin
                            r_entry_err <= 1'b1;
                        end else if (door_closed) begin
                            r_state <= c_ST_LOAD;
                            r_loadn <= 1'b0;
                        end
                    end else if (w_key_ok) begin
                        r_min   <= r_tens;
                        r_tens  <= r_ones;
                        r_ones  <= key_code;
                        r_state <= c_ST_ENTRY;
                    end
                end
                c_ST_LOAD: begin
                    r_state   <= c_ST_RUN;
                    r_heat_on <= 1'b1;
                end
                c_ST_RUN: begin
                    if (timer_zero) begin
                        r_state   <= c_ST_DONE;
                        r_heat_on <= 1'b0;
                        r_done    <= 1'b1;
                        r_min     <= 4'd0;
                        r_tens    <= 4'd0;
                        r_ones    <= 4'd0;
                    end else if (stop || !door_closed) begin
                        r_state   <= c_ST_PAUSE;
                        r_heat_on <= 1'b0;
                    end else begin
                        // Door is known closed here, so the tick alone enables
                        r_en_count <= tick;
                    end
                end
                c_ST_PAUSE: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                        r_min   <= 4'd0;
                        r_tens  <= 4'd0;
                        r_ones  <= 4'd0;
                    end else if (start && door_closed) begin
                        r_state   <= c_ST_RUN;
                        r_heat_on <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_heat_on <= 1'b0;
                end
            endcase
        end
    end

    assign data_min  = r_min;
    assign data_tens = r_tens;
    assign data_ones = r_ones;
    assign loadn     = r_loadn;
    assign en_count  = r_en_count;
    assign heat_on   = r_heat_on;
    assign done      = r_done;
    assign entry_err = r_entry_err;

endmodule
`default_nettype wire

// File: tb/tb_time_entry_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_entry_loader
//  Description : Bench for time_entry_loader. A reference model holds the
//                entry as a decimal number 0..999 and a mode, and every
//                cycle the DUT outputs are compared against it. Directed
//                scenarios add literal expectations, then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_entry_loader;

    localparam int c_M_IDLE  = 0;
    localparam int c_M_ENTRY = 1;
    localparam int c_M_LOAD  = 2;
    localparam int c_M_RUN   = 3;
    localparam int c_M_PAUSE = 4;
    localparam int c_M_DONE  = 5;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       tick = 1'b0;
    logic       timer_zero = 1'b0;
    logic [3:0] data_min, data_tens, data_ones;
    logic       loadn, en_count, heat_on, done, entry_err;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_mode  = c_M_IDLE;
    int m_entry = 0;
    bit m_en    = 1'b0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    time_entry_loader #(.MAX_TENS(5), .MAX_DIGIT(9)) dut (
        .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
        .start(start), .stop(stop), .door_closed(door_closed), .tick(tick),
        .timer_zero(timer_zero), .data_min(data_min), .data_tens(data_tens),
        .data_ones(data_ones), .loadn(loadn), .en_count(en_count),
        .heat_on(heat_on), .done(done), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: entry is a plain decimal number, keys append a digit
    always @(posedge clk) begin
        automatic int md = m_mode;
        automatic int e  = m_entry;
        automatic bit en = 1'b0;
        automatic bit er = 1'b0;
        if (clr) begin
            md = c_M_IDLE;
            e  = 0;
            m_valid <= 1'b1;
        end else begin
            case (md)
                c_M_IDLE, c_M_ENTRY: begin
                    if (stop) begin
                        e = 0; md = c_M_IDLE;
                    end else if (md == c_M_ENTRY && start) begin
                        if (e == 0) md = c_M_ENTRY;
                        else if ((e / 10) % 10 > 5) er = 1'b1;
                        else if (door_closed) md = c_M_LOAD;
                    end else if (key_valid && key_code <= 4'd9) begin
                        e = (e * 10 + int'(key_code)) % 1000;
                        md = c_M_ENTRY;
                    end
                end
                c_M_LOAD: md = c_M_RUN;
                c_M_RUN: begin
                    if (timer_zero) begin
                        md = c_M_DONE; e = 0;
                    end else if (stop || !door_closed) md = c_M_PAUSE;
                    else en = tick;
                end
                c_M_PAUSE: begin
                    if (stop) begin
                        md = c_M_IDLE; e = 0;
                    end else if (start && door_closed) md = c_M_RUN;
                end
                default: md = c_M_IDLE;
            endcase
        end
        m_mode  <= md;
        m_entry <= e;
        m_en    <= en;
        m_err   <= er;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("data_min",  data_min,  4'(m_entry / 100));
            chk("data_tens", data_tens, 4'((m_entry / 10) % 10));
            chk("data_ones", data_ones, 4'(m_entry % 10));
            chk("loadn",     {3'd0, loadn},     {3'd0, m_mode != c_M_LOAD});
            chk("heat_on",   {3'd0, heat_on},   {3'd0, m_mode == c_M_RUN});
            chk("done",      {3'd0, done},      {3'd0, m_mode == c_M_DONE});
            chk("en_count",  {3'd0, en_count},  {3'd0, m_en});
            chk("entry_err", {3'd0, entry_err}, {3'd0, m_err});
        end
    end

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input int k);
        key_valid = 1'b1; key_code = 4'(k);
        adv();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        adv();
        start = 1'b0;
    endtask

    task automatic to_run();
        press(1); press(3); press(0);
        pulse_start();
        adv();
    endtask

    initial begin
        adv(); adv();
        clr = 1'b0;
        chk("rst_data", data_min | data_tens | data_ones, 4'd0);
        chk("rst_loadn", {3'd0, loadn}, 4'd1);
        chk("rst_heat", {3'd0, heat_on}, 4'd0);

        // Keys 1,3,0 then start: one-cycle load, then run with tick-driven enable
        press(1); press(3); press(0);
        chk("k130_min", data_min, 4'd1);
        chk("k130_tens", data_tens, 4'd3);
        chk("k130_ones", data_ones, 4'd0);
        pulse_start();
        chk("load_low", {3'd0, loadn}, 4'd0);
        adv();
        chk("load_high", {3'd0, loadn}, 4'd1);
        chk("run_heat", {3'd0, heat_on}, 4'd1);
        tick = 1'b1; adv(); tick = 1'b0;
        chk("en_pulse", {3'd0, en_count}, 4'd1);
        adv();
        chk("en_off", {3'd0, en_count}, 4'd0);

        // Door opens, then close and resume without reload
        door_closed = 1'b0; tick = 1'b1; adv(); tick = 1'b0;
        chk("door_heat", {3'd0, heat_on}, 4'd0);
        chk("door_en", {3'd0, en_count}, 4'd0);
        door_closed = 1'b1;
        pulse_start();
        chk("resume_heat", {3'd0, heat_on}, 4'd1);
        chk("resume_loadn", {3'd0, loadn}, 4'd1);

        // timer_zero together with stop still finishes
        timer_zero = 1'b1; stop = 1'b1; adv(); timer_zero = 1'b0; stop = 1'b0;
        chk("done_pulse", {3'd0, done}, 4'd1);
        chk("done_data", data_min | data_tens | data_ones, 4'd0);
        adv();
        chk("done_end", {3'd0, done}, 4'd0);

        // Out-of-range tens digit rejected, illegal key ignored
        press(0); press(7); press(5);
        pulse_start();
        chk("err_pulse", {3'd0, entry_err}, 4'd1);
        chk("err_loadn", {3'd0, loadn}, 4'd1);
        chk("err_tens", data_tens, 4'd7);
        press(12);
        chk("err_clear", {3'd0, entry_err}, 4'd0);
        chk("k12_ones", data_ones, 4'd5);
        chk("k12_tens", data_tens, 4'd7);
        stop = 1'b1; adv(); stop = 1'b0;

        // Pause, then start and stop together: stop wins
        to_run();
        stop = 1'b1; adv(); stop = 1'b0;
        chk("pause_heat", {3'd0, heat_on}, 4'd0);
        start = 1'b1; stop = 1'b1; adv(); start = 1'b0; stop = 1'b0;
        chk("ss_data", data_min | data_tens | data_ones, 4'd0);
        pulse_start();
        chk("idle_start", {3'd0, heat_on}, 4'd0);

        // All-zero entry cannot start
        press(0);
        pulse_start();
        chk("zero_loadn", {3'd0, loadn}, 4'd1);

        // Reset mid-run
        stop = 1'b1; adv(); stop = 1'b0;
        to_run();
        clr = 1'b1; adv(); clr = 1'b0;
        chk("mrst_heat", {3'd0, heat_on}, 4'd0);
        chk("mrst_data", data_min | data_tens | data_ones, 4'd0);
        chk("mrst_loadn", {3'd0, loadn}, 4'd1);

        // Random traffic, checked every cycle by the model comparator
        for (int i = 0; i < 4000; i++) begin
            key_valid  = ($urandom_range(0, 99) < 30);
            key_code   = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 5))
                                                      : 4'($urandom_range(0, 15));
            start      = ($urandom_range(0, 99) < 12);
            stop       = ($urandom_range(0, 99) < 4);
            tick       = ($urandom_range(0, 99) < 25);
            timer_zero = ($urandom_range(0, 99) < 3);
            clr        = ($urandom_range(0, 999) < 5);
            if ($urandom_range(0, 99) < 4) door_closed = ~door_closed;
            adv();
        end
        key_valid = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        timer_zero = 1'b0; clr = 1'b0;
        adv(); adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
